// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the execute-path shifter: operation
//               codes, the operation type and a constant log2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [2:0] sh_op_t;

    localparam sh_op_t SH_SRL  = 3'b000;
    localparam sh_op_t SH_SLL  = 3'b001;
    localparam sh_op_t SH_SRA  = 3'b010;
    localparam sh_op_t SH_PASS = 3'b011;
    localparam sh_op_t SH_ROR  = 3'b100;
    localparam sh_op_t SH_ROL  = 3'b101;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_level.sv
`default_nettype none
// ============================================================================
// Module      : shift_level
// Description : One combinational barrel-shifter level. Shifts or rotates the
//               incoming word by 2**K when enabled; otherwise passes it on.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_level
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    input  sh_op_t           i_op,
    output logic [WIDTH-1:0] o_data
);

    localparam int c_AMT = 1 << K;

    // Apply this level's fixed distance; PASS and the spare codes leave data alone.
    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                SH_SRL:  o_data = i_data >> c_AMT;
                SH_SLL:  o_data = i_data << c_AMT;
                SH_SRA:  o_data = WIDTH'($signed(i_data) >>> c_AMT);
                SH_ROR:  o_data = {i_data[c_AMT-1:0], i_data[WIDTH-1:c_AMT]};
                SH_ROL:  o_data = {i_data[WIDTH-c_AMT-1:0], i_data[WIDTH-1:WIDTH-c_AMT]};
                default: o_data = i_data;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_shifter
// Description : Parametrised pipelined barrel shifter with valid/ready
//               handshake, backpressure, flush and a pass-through tag.
//               log2(WIDTH) shift levels are spread over STAGES registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [clog2(WIDTH)-1:0]  in_shamt,
    input  sh_op_t                   in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_r,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy
);

    localparam int c_LEVELS = clog2(WIDTH);

    typedef logic [c_LEVELS-1:0] shamt_t;

    // Stage in which shift level k is evaluated.
    function automatic int stage_of(input int k);
        return (k * STAGES) / c_LEVELS;
    endfunction

    // Stage registers
    logic [STAGES-1:0]  r_valid;
    logic [WIDTH-1:0]   r_data  [STAGES];
    shamt_t             r_shamt [STAGES];
    sh_op_t             r_op    [STAGES];
    logic [TAG_W-1:0]   r_tag   [STAGES];

    // Per-stage inputs (previous register or the issue port) and results
    logic [STAGES-1:0]  w_sin_valid;
    logic [WIDTH-1:0]   w_sin_data  [STAGES];
    shamt_t             w_sin_shamt [STAGES];
    sh_op_t             w_sin_op    [STAGES];
    logic [TAG_W-1:0]   w_sin_tag   [STAGES];
    logic [WIDTH-1:0]   w_sout_data [STAGES];
    logic [STAGES-1:0]  w_load;
    logic               w_unused_ctrl;

    genvar s, k;

    generate
        for (s = 0; s < STAGES; s++) begin : g_stage
            if (s == 0) begin : g_issue
                assign w_sin_valid[s] = in_valid;
                assign w_sin_data[s]  = in_a;
                assign w_sin_shamt[s] = in_shamt;
                assign w_sin_op[s]    = in_op;
                assign w_sin_tag[s]   = in_tag;
            end else begin : g_chain
                assign w_sin_valid[s] = r_valid[s-1];
                assign w_sin_data[s]  = r_data[s-1];
                assign w_sin_shamt[s] = r_shamt[s-1];
                assign w_sin_op[s]    = r_op[s-1];
                assign w_sin_tag[s]   = r_tag[s-1];
            end
        end

        for (k = 0; k < c_LEVELS; k++) begin : g_level
            localparam int c_S     = stage_of(k);
            localparam bit c_FIRST = (k == 0) || (stage_of(k - 1) != c_S);
            localparam bit c_LAST  = (k == c_LEVELS - 1) || (stage_of(k + 1) != c_S);

            logic [WIDTH-1:0] w_lvl_in;
            logic [WIDTH-1:0] w_lvl_out;

            if (c_FIRST) begin : g_head
                assign w_lvl_in = w_sin_data[c_S];
            end else begin : g_link
                assign w_lvl_in = g_level[k-1].w_lvl_out;
            end

            shift_level #(
                .WIDTH (WIDTH),
                .K     (k)
            ) u_level (
                .i_data (w_lvl_in),
                .i_en   (w_sin_shamt[c_S][k]),
                .i_op   (w_sin_op[c_S]),
                .o_data (w_lvl_out)
            );

            if (c_LAST) begin : g_tail
                assign w_sout_data[c_S] = w_lvl_out;
            end
        end
    endgenerate

    // A stage may load when empty or when its occupant moves on this cycle;
    // the chain runs back from out_ready so a full pipe can stream.
    always_comb begin
        logic v_down;
        w_load = '0;
        v_down = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_load[i] = !r_valid[i] || v_down;
            v_down    = w_load[i];
        end
    end

    // Consumed shamt bits and last-stage control are carried for uniform
    // stage registers; fold them here so they are not reported as dead.
    always_comb begin
        w_unused_ctrl = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            w_unused_ctrl = w_unused_ctrl ^ (^r_shamt[i]) ^ (^r_op[i]);
        end
    end

    // Stage registers: flush kills everything, otherwise load when allowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i]  <= '0;
                r_shamt[i] <= '0;
                r_op[i]    <= SH_SRL;
                r_tag[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush) begin
                    r_valid[i] <= 1'b0;
                end else if (w_load[i]) begin
                    r_valid[i] <= w_sin_valid[i];
                    if (w_sin_valid[i]) begin
                        r_data[i]  <= w_sout_data[i];
                        r_shamt[i] <= w_sin_shamt[i];
                        r_op[i]    <= w_sin_op[i];
                        r_tag[i]   <= w_sin_tag[i];
                    end
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[STAGES-1];
    assign out_r     = r_data[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];
    assign busy      = |r_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_shifter
// Description : Directed self-checking bench for pipelined_shifter, covering a
//               32-bit/2-stage instance and a 64-bit/6-stage instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_shifter;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_a, out_r;
    logic [4:0]  in_shamt, in_tag, out_tag;
    sh_op_t      in_op;

    logic        flush_w, in_valid_w, in_ready_w, out_valid_w, out_ready_w, busy_w;
    logic [63:0] in_a_w, out_r_w;
    logic [5:0]  in_shamt_w;
    logic [4:0]  in_tag_w, out_tag_w;
    sh_op_t      in_op_w;

    int total = 0;
    int bad   = 0;

    pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag),
        .busy(busy)
    );

    pipelined_shifter #(.WIDTH(64), .STAGES(6), .TAG_W(5)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_a(in_a_w), .in_shamt(in_shamt_w), .in_op(in_op_w), .in_tag(in_tag_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_r(out_r_w), .out_tag(out_tag_w),
        .busy(busy_w)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  sh;
        sh_op_t      op;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [63:0] a;
        logic [5:0]  sh;
        sh_op_t      op;
        logic [63:0] exp;
    } vecw_t;

    vec_t vecs [16] = '{
        '{32'h8000_00F0, 5'd4,  SH_SRA,  32'hF800_000F},
        '{32'h8000_00F0, 5'd4,  SH_SRL,  32'h0800_000F},
        '{32'h8000_0001, 5'd1,  SH_ROL,  32'h0000_0003},
        '{32'h8000_0001, 5'd1,  SH_ROR,  32'hC000_0000},
        '{32'h8000_0001, 5'd1,  SH_SLL,  32'h0000_0002},
        '{32'h1234_5678, 5'd7,  SH_PASS, 32'h1234_5678},
        '{32'h1234_5678, 5'd9,  3'b111,  32'h1234_5678},
        '{32'hDEAD_BEEF, 5'd0,  SH_SRA,  32'hDEAD_BEEF},
        '{32'h8000_0000, 5'd31, SH_SRA,  32'hFFFF_FFFF},
        '{32'h8000_0000, 5'd31, SH_SRL,  32'h0000_0001},
        '{32'h1234_5678, 5'd16, SH_ROR,  32'h5678_1234},
        '{32'h1234_5678, 5'd4,  SH_ROL,  32'h2345_6781},
        '{32'h7FFF_FFFF, 5'd31, SH_SRA,  32'h0000_0000},
        '{32'h0000_00FF, 5'd28, SH_SLL,  32'hF000_0000},
        '{32'h1234_5678, 5'd31, SH_ROL,  32'h091A_2B3C},
        '{32'h0000_0001, 5'd3,  3'b110,  32'h0000_0001}
    };

    vecw_t vw [10] = '{
        '{64'h8000_0000_0000_00F0, 6'd4,  SH_SRA, 64'hF800_0000_0000_000F},
        '{64'h8000_0000_0000_0001, 6'd1,  SH_ROL, 64'h0000_0000_0000_0003},
        '{64'h8000_0000_0000_0001, 6'd1,  SH_ROR, 64'hC000_0000_0000_0000},
        '{64'h0000_0000_0000_0001, 6'd63, SH_SLL, 64'h8000_0000_0000_0000},
        '{64'h8000_0000_0000_0000, 6'd63, SH_SRL, 64'h0000_0000_0000_0001},
        '{64'h0123_4567_89AB_CDEF, 6'd32, SH_ROR, 64'h89AB_CDEF_0123_4567},
        '{64'h0123_4567_89AB_CDEF, 6'd4,  SH_ROL, 64'h1234_5678_9ABC_DEF0},
        '{64'h7FFF_0000_0000_0000, 6'd63, SH_SRA, 64'h0000_0000_0000_0000},
        '{64'hF000_0000_0000_0000, 6'd62, SH_SRA, 64'hFFFF_FFFF_FFFF_FFFF},
        '{64'h0123_4567_89AB_CDEF, 6'd63, SH_ROL, 64'h8091_A2B3_C4D5_E6F7}
    };

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_shamt = '0; in_op = SH_SRL; in_tag = '0;
        flush_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b1;
        in_a_w = '0; in_shamt_w = '0; in_op_w = SH_SRL; in_tag_w = '0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (out_r !== 32'h0) begin bad++; $display("FAIL rst_out_r got=%08h exp=0", out_r); end
        total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL rst_out_tag got=%0h exp=0", out_tag); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step(); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%0b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_vectors();
        logic [4:0] tag;
        for (int i = 0; i < 16; i++) begin
            tag = 5'h1A ^ 5'(i);
            step();
            in_valid = 1'b1; in_a = vecs[i].a; in_shamt = vecs[i].sh; in_op = vecs[i].op; in_tag = tag;
            step();
            in_valid = 1'b0;
            #1;
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL vec%0d_busy got=%0b exp=1", i, busy); end
            step(); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_valid got=%0b exp=1", i, out_valid); end
            total++; if (out_r !== vecs[i].exp) begin bad++; $display("FAIL vec%0d_data got=%08h exp=%08h", i, out_r, vecs[i].exp); end
            total++; if (out_tag !== tag) begin bad++; $display("FAIL vec%0d_tag got=%0h exp=%0h", i, out_tag, tag); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int rcv = 0, first = -1, last = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            if (c < 8) begin
                in_valid = 1'b1; in_a = 32'h1; in_op = SH_SLL; in_shamt = 5'(3 * c); in_tag = 5'(c);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 8) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%0b exp=1", c, in_ready); end
            end
            if (out_valid === 1'b1) begin
                total++;
                if (rcv >= 8) begin
                    bad++; $display("FAIL b2b_extra cyc=%0d got=%08h exp=none", c, out_r);
                end else if (out_r !== (32'h1 << (3 * rcv)) || out_tag !== 5'(rcv)) begin
                    bad++; $display("FAIL b2b_data idx=%0d got=%08h/%0h exp=%08h/%0h", rcv, out_r, out_tag, 32'h1 << (3 * rcv), rcv);
                end
                if (first < 0) first = c;
                last = c;
                rcv++;
            end
        end
        total++; if (rcv !== 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", rcv); end
        total++; if (first !== 2) begin bad++; $display("FAIL b2b_latency got=%0d exp=2", first); end
        total++; if (last - first !== 7) begin bad++; $display("FAIL b2b_gap got=%0d exp=7", last - first); end
    endtask

    task automatic test_backpressure();
        int sent = 0, rcv = 0;
        logic [31:0] exp_d;
        for (int c = 0; c < 20; c++) begin
            step();
            out_ready = (c >= 4);
            if (sent < 4) begin
                in_valid = 1'b1; in_a = 32'hF000_0000; in_op = SH_SRL; in_shamt = 5'(sent); in_tag = 5'(sent + 3);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 2) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=1", c, in_ready); end
            end else if (c < 4) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", c, in_ready); end
            end
            if (out_valid === 1'b1) begin
                total++;
                exp_d = 32'hF000_0000 >> rcv;
                if (rcv >= 4) begin
                    bad++; $display("FAIL bp_dup cyc=%0d got=%08h exp=none", c, out_r);
                end else if (out_r !== exp_d || out_tag !== 5'(rcv + 3)) begin
                    bad++; $display("FAIL bp_data cyc=%0d got=%08h/%0h exp=%08h/%0h", c, out_r, out_tag, exp_d, rcv + 3);
                end
                if (out_ready) rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        total++; if (rcv !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", rcv); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0b exp=0", busy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        step();
        in_valid = 1'b1; in_a = 32'h1; in_op = SH_SLL; in_shamt = 5'd1; in_tag = 5'd1;
        step();
        in_shamt = 5'd2; in_tag = 5'd2;
        step();
        in_shamt = 5'd3; in_tag = 5'd3; flush = 1'b1;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%0b exp=1", out_valid); end
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0b exp=0", busy); end
        for (int c = 0; c < 4; c++) begin
            step(); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost cyc=%0d got=%08h exp=none", c, out_r); end
        end
        step();
        in_valid = 1'b1; in_a = 32'h8000_0000; in_op = SH_SRA; in_shamt = 5'd1; in_tag = 5'd7;
        step();
        in_valid = 1'b0;
        step(); #1;
        total++; if (out_valid !== 1'b1 || out_r !== 32'hC000_0000 || out_tag !== 5'd7) begin
            bad++; $display("FAIL flush_after got=%0b/%08h/%0h exp=1/c0000000/7", out_valid, out_r, out_tag);
        end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_a = 32'hFFFF_0000; in_op = SH_ROR; in_shamt = 5'd8; in_tag = 5'd9;
        step();
        in_valid = 1'b0;
        step(); #1;
        total++; if (out_valid !== 1'b1 || out_r !== 32'h00FF_FF00) begin
            bad++; $display("FAIL arst_pre got=%0b/%08h exp=1/00ffff00", out_valid, out_r);
        end
        #1 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%0b exp=0", busy); end
        total++; if (out_r !== 32'h0 || in_ready !== 1'b1) begin bad++; $display("FAIL arst_state got=%08h/%0b exp=0/1", out_r, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_a = 32'h1; in_op = SH_SLL; in_shamt = 5'd31; in_tag = 5'h1F;
        step();
        in_valid = 1'b0;
        step(); #1;
        total++; if (out_valid !== 1'b1 || out_r !== 32'h8000_0000 || out_tag !== 5'h1F) begin
            bad++; $display("FAIL arst_after got=%0b/%08h/%0h exp=1/80000000/1f", out_valid, out_r, out_tag);
        end
        step();
    endtask

    task automatic test_wide();
        int rcv = 0, first = -1, last = -1;
        out_ready_w = 1'b1;
        for (int c = 0; c < 24; c++) begin
            step();
            if (c < 10) begin
                in_valid_w = 1'b1; in_a_w = vw[c].a; in_shamt_w = vw[c].sh; in_op_w = vw[c].op; in_tag_w = 5'(c + 10);
            end else begin
                in_valid_w = 1'b0;
            end
            #1;
            if (c < 10) begin
                total++; if (in_ready_w !== 1'b1) begin bad++; $display("FAIL wide_in_ready cyc=%0d got=%0b exp=1", c, in_ready_w); end
            end
            if (out_valid_w === 1'b1) begin
                total++;
                if (rcv >= 10) begin
                    bad++; $display("FAIL wide_extra cyc=%0d got=%016h exp=none", c, out_r_w);
                end else if (out_r_w !== vw[rcv].exp || out_tag_w !== 5'(rcv + 10)) begin
                    bad++; $display("FAIL wide_data idx=%0d got=%016h/%0h exp=%016h/%0h", rcv, out_r_w, out_tag_w, vw[rcv].exp, rcv + 10);
                end
                if (first < 0) first = c;
                last = c;
                rcv++;
            end
        end
        total++; if (rcv !== 10) begin bad++; $display("FAIL wide_count got=%0d exp=10", rcv); end
        total++; if (first !== 6) begin bad++; $display("FAIL wide_latency got=%0d exp=6", first); end
        total++; if (last - first !== 9) begin bad++; $display("FAIL wide_gap got=%0d exp=9", last - first); end
        total++; if (busy_w !== 1'b0) begin bad++; $display("FAIL wide_busy got=%0b exp=0", busy_w); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
